// File: rtl/tcp_tcb_table_pkg.sv
// Shared TCP types for the RX path: decoded segment, control block, connection
// states, and the key-compare helper used by the TCB table.
package tcp;

  localparam int BUFF_WIDTH  = 16;
  localparam int TCB_IDX_MAX = 15;

  typedef enum logic [3:0] {
    CLOSED,
    LISTEN,
    SYN_SENT,
    SYN_RCVD,
    ESTABLISHED,
    FIN_WAIT_1,
    FIN_WAIT_2,
    CLOSE_WAIT,
    CLOSING,
    LAST_ACK,
    TIME_WAIT
  } tcp_state_e;

  typedef struct packed {
    logic [15:0]           peer_port;
    logic [31:0]           ip_source_addr;
    logic [31:0]           sequence_num;
    logic [31:0]           ack_num;
    logic [15:0]           window;
    logic [BUFF_WIDTH-1:0] payload_addr;
  } packet_t;

  typedef struct packed {
    logic [15:0] peer_port;
    logic [31:0] peer_ip;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [15:0] window;
    logic [15:0] mss;
    tcp_state_e  state;
  } tcb_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DISPATCH,
    WRITEBACK
  } tbl_state_e;

  // A connection is identified by the remote endpoint only.
  function automatic logic tcb_key_match(input tcb_t t, input packet_t p);
    return (t.peer_ip == p.ip_source_addr) && (t.peer_port == p.peer_port);
  endfunction

endpackage

// File: rtl/tcp_tcb_table_alloc.sv
// Free-slot priority encoder for the TCB table; with TCP_TCB_EVICT_EN defined it
// also keeps the round-robin eviction pointer.
module tcp_tcb_alloc #(
  parameter  int N_CONN = 4,
  localparam int IDX_W  = $clog2(N_CONN)
) (
`ifdef TCP_TCB_EVICT_EN
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] victim_idx_o,
`endif
  input  logic [N_CONN-1:0] occupied_i,
  output logic [IDX_W-1:0]  free_idx_o,
  output logic              any_free_o
);

  // Scan from the top down so the lowest free index wins.
  always_comb begin
    free_idx_o = '0;
    for (int i = N_CONN - 1; i >= 0; i--) begin
      if (!occupied_i[i]) free_idx_o = IDX_W'(i);
    end
  end

  assign any_free_o = ~(&occupied_i);

`ifdef TCP_TCB_EVICT_EN
  logic [IDX_W-1:0] victim_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      victim_q <= '0;
    end else if (advance_i) begin
      victim_q <= (victim_q == IDX_W'(N_CONN - 1)) ? '0 : victim_q + IDX_W'(1);
    end
  end

  assign victim_idx_o = victim_q;
`endif

endmodule

// File: rtl/tcp_tcb_table.sv
// Multi-connection TCB store/dispatcher between the TCP header decoder and the
// connection state machine. Define TCP_TCB_EVICT_EN to evict instead of drop when full.
module tcp_tcb_table
  import tcp::*;
#(
  parameter  int N_CONN = 4,
  parameter  int MSS    = 1464,
  localparam int IDX_W  = $clog2(N_CONN),
  localparam int CNT_W  = $clog2(N_CONN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  packet_t               pkt,
  output logic                  sm_valid,
  output tcb_t                  o_tcb,
  output logic [IDX_W-1:0]      o_idx,
  input  logic                  sm_done,
  input  logic                  sm_accept_payload,
  input  tcb_t                  i_tcb,
  output logic                  tcp_payload_valid,
  output logic [BUFF_WIDTH-1:0] tcp_payload_addr,
  output logic [IDX_W-1:0]      tcp_payload_conn,
  output logic                  pkt_drop,
  output logic [CNT_W-1:0]      conn_count
);

  tbl_state_e            state_q, state_d;
  packet_t               pkt_q, pkt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_CONN-1:0]     occupied_q, occupied_d;
  logic                  ready_q;
  logic                  payValid_q, payValid_d;
  logic [BUFF_WIDTH-1:0] payAddr_q, payAddr_d;
  logic [IDX_W-1:0]      payConn_q, payConn_d;
  logic                  drop_q, drop_d;

  tcb_t                  tcbs_q [N_CONN];
  logic                  tblWe;
  logic [IDX_W-1:0]      tblIdx;
  tcb_t                  tblData;
  tcb_t                  newTcb;

  logic [N_CONN-1:0]     hitVec;
  logic                  hit;
  logic [IDX_W-1:0]      hitIdx;
  logic [IDX_W-1:0]      freeIdx;
  logic                  anyFree;

`ifdef TCP_TCB_EVICT_EN
  logic                  evict;
  logic [IDX_W-1:0]      victimIdx;
`endif

  tcp_tcb_alloc #(
    .N_CONN(N_CONN)
  ) u_alloc (
`ifdef TCP_TCB_EVICT_EN
    .clk_i       (clk),
    .rst_i       (rst),
    .advance_i   (evict),
    .victim_idx_o(victimIdx),
`endif
    .occupied_i  (occupied_q),
    .free_idx_o  (freeIdx),
    .any_free_o  (anyFree)
  );

  always_comb begin
    hitVec = '0;
    hitIdx = '0;
    for (int i = 0; i < N_CONN; i++) begin
      hitVec[i] = occupied_q[i] && tcb_key_match(tcbs_q[i], pkt_q);
      if (hitVec[i]) hitIdx = IDX_W'(i);
    end
  end

  assign hit = |hitVec;

  // Fresh TCB for a newly seen peer: key from the segment, counters zeroed.
  always_comb begin
    newTcb           = '0;
    newTcb.peer_ip   = pkt_q.ip_source_addr;
    newTcb.peer_port = pkt_q.peer_port;
    newTcb.mss       = 16'(MSS);
    newTcb.state     = LISTEN;
  end

  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    idx_d      = idx_q;
    occupied_d = occupied_q;
    payValid_d = 1'b0;
    payAddr_d  = payAddr_q;
    payConn_d  = payConn_q;
    drop_d     = 1'b0;
    tblWe      = 1'b0;
    tblIdx     = idx_q;
    tblData    = tcbs_q[idx_q];
`ifdef TCP_TCB_EVICT_EN
    evict      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (valid) begin
          pkt_d   = pkt;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit) begin
          tblWe                = 1'b1;
          tblIdx               = hitIdx;
          tblData              = tcbs_q[hitIdx];
          tblData.seq_num      = pkt_q.sequence_num;
          tblData.ack_num      = pkt_q.ack_num;
          tblData.window       = pkt_q.window;
          idx_d                = hitIdx;
          state_d              = DISPATCH;
        end else if (anyFree) begin
          tblWe                = 1'b1;
          tblIdx               = freeIdx;
          tblData              = newTcb;
          occupied_d[freeIdx]  = 1'b1;
          idx_d                = freeIdx;
          state_d              = DISPATCH;
        end else begin
`ifdef TCP_TCB_EVICT_EN
          tblWe                = 1'b1;
          tblIdx               = victimIdx;
          tblData              = newTcb;
          idx_d                = victimIdx;
          evict                = 1'b1;
          state_d              = DISPATCH;
`else
          drop_d               = 1'b1;
          state_d              = IDLE;
`endif
        end
      end

      DISPATCH: begin
        if (sm_done) begin
          tblWe   = 1'b1;
          tblIdx  = idx_q;
          tblData = i_tcb;
          if (i_tcb.state == CLOSED) occupied_d[idx_q] = 1'b0;
          if (sm_accept_payload) begin
            payValid_d = 1'b1;
            payAddr_d  = pkt_q.payload_addr;
            payConn_d  = idx_q;
          end
          state_d = WRITEBACK;
        end
      end

      WRITEBACK: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // ready is registered so it stays low throughout reset and rises one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      idx_q      <= '0;
      occupied_q <= '0;
      ready_q    <= 1'b0;
      payValid_q <= 1'b0;
      payAddr_q  <= '0;
      payConn_q  <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      idx_q      <= idx_d;
      occupied_q <= occupied_d;
      ready_q    <= (state_d == IDLE);
      payValid_q <= payValid_d;
      payAddr_q  <= payAddr_d;
      payConn_q  <= payConn_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tblWe) tcbs_q[tblIdx] <= tblData;
  end

  always_comb begin
    conn_count = '0;
    for (int i = 0; i < N_CONN; i++) begin
      conn_count = conn_count + CNT_W'(occupied_q[i]);
    end
  end

  assign ready             = ready_q;
  assign sm_valid          = (state_q == DISPATCH);
  assign o_tcb             = sm_valid ? tcbs_q[idx_q] : '0;
  assign o_idx             = idx_q;
  assign tcp_payload_valid = payValid_q;
  assign tcp_payload_addr  = payAddr_q;
  assign tcp_payload_conn  = payConn_q;
  assign pkt_drop          = drop_q;

  a_unique_hit: assert property (@(posedge clk) disable iff (rst)
    (state_q == LOOKUP) |-> $onehot0(hitVec));

  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    int'(idx_q) <= TCB_IDX_MAX);

endmodule

// File: tb/tb_tcp_tcb_table.sv
// Directed self-checking bench for tcp_tcb_table; expectations follow the
// TCP_TCB_EVICT_EN setting of the build.
module tb_tcp_tcb_table;
  import tcp::*;

  localparam int N_CONN = 4;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  valid = 1'b0;
  logic                  ready;
  packet_t               pkt = '0;
  logic                  sm_valid;
  tcb_t                  o_tcb;
  logic [IDX_W-1:0]      o_idx;
  logic                  sm_done = 1'b0;
  logic                  sm_accept_payload = 1'b0;
  tcb_t                  i_tcb = '0;
  logic                  tcp_payload_valid;
  logic [BUFF_WIDTH-1:0] tcp_payload_addr;
  logic [IDX_W-1:0]      tcp_payload_conn;
  logic                  pkt_drop;
  logic [CNT_W-1:0]      conn_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tcp_tcb_table #(.N_CONN(N_CONN), .MSS(1464)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid            (valid),
    .ready            (ready),
    .pkt              (pkt),
    .sm_valid         (sm_valid),
    .o_tcb            (o_tcb),
    .o_idx            (o_idx),
    .sm_done          (sm_done),
    .sm_accept_payload(sm_accept_payload),
    .i_tcb            (i_tcb),
    .tcp_payload_valid(tcp_payload_valid),
    .tcp_payload_addr (tcp_payload_addr),
    .tcp_payload_conn (tcp_payload_conn),
    .pkt_drop         (pkt_drop),
    .conn_count       (conn_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic tcb_t mkTcb(input logic [31:0] ip, input logic [15:0] port,
                                 input logic [31:0] seq, input tcp_state_e st);
    tcb_t t;
    t           = '0;
    t.peer_ip   = ip;
    t.peer_port = port;
    t.seq_num   = seq;
    t.mss       = 16'd1464;
    t.state     = st;
    return t;
  endfunction

  // Waits (bounded) for ready, offers one segment, returns on the LOOKUP cycle.
  task automatic applyStimulus(input logic [31:0] ip, input logic [15:0] port,
                               input logic [31:0] seq, input logic [31:0] ack,
                               input logic [15:0] win, input logic [15:0] paddr);
    int waitCycles;
    waitCycles = 0;
    while (ready !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("ready_wait", {63'd0, ready}, 64'd1);
    pkt.ip_source_addr = ip;
    pkt.peer_port      = port;
    pkt.sequence_num   = seq;
    pkt.ack_num        = ack;
    pkt.window         = win;
    pkt.payload_addr   = paddr;
    valid              = 1'b1;
    @(negedge clk);
    valid              = 1'b0;
  endtask

  // Answers the dispatch; returns on the WRITEBACK cycle.
  task automatic finishDispatch(input tcb_t t, input logic accept);
    sm_done           = 1'b1;
    sm_accept_payload = accept;
    i_tcb             = t;
    @(negedge clk);
    sm_done           = 1'b0;
    sm_accept_payload = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(negedge clk);
    checkOutput("rst_ready",    {63'd0, ready}, 64'd0);
    checkOutput("rst_sm_valid", {63'd0, sm_valid}, 64'd0);
    checkOutput("rst_count",    64'(conn_count), 64'd0);
    checkOutput("rst_drop",     {63'd0, pkt_drop}, 64'd0);
    checkOutput("rst_payv",     {63'd0, tcp_payload_valid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", {63'd0, ready}, 64'd1);

    // New peer 10.0.0.2:5000 allocates slot 0 as LISTEN
    applyStimulus(32'h0A00_0002, 16'd5000, 32'h55, 32'h66, 16'd100, 16'h10);
    checkOutput("lookup_no_valid", {63'd0, sm_valid}, 64'd0);
    checkOutput("lookup_ready",    {63'd0, ready}, 64'd0);
    @(negedge clk);
    checkOutput("alloc_sm_valid", {63'd0, sm_valid}, 64'd1);
    checkOutput("alloc_idx",      64'(o_idx), 64'd0);
    checkOutput("alloc_state",    64'(o_tcb.state), 64'(LISTEN));
    checkOutput("alloc_seq_zero", 64'(o_tcb.seq_num), 64'd0);
    checkOutput("alloc_port",     64'(o_tcb.peer_port), 64'd5000);
    checkOutput("alloc_mss",      64'(o_tcb.mss), 64'd1464);
    checkOutput("alloc_count",    64'(conn_count), 64'd1);
    finishDispatch(mkTcb(32'h0A00_0002, 16'd5000, 32'h11, ESTABLISHED), 1'b0);
    checkOutput("wb_no_payload", {63'd0, tcp_payload_valid}, 64'd0);

    // Same peer again: hit on slot 0 with the segment's seq/ack/window
    applyStimulus(32'h0A00_0002, 16'd5000, 32'h1000, 32'h2000, 16'd512, 16'h40);
    @(negedge clk);
    checkOutput("hit_idx",    64'(o_idx), 64'd0);
    checkOutput("hit_seq",    64'(o_tcb.seq_num), 64'h1000);
    checkOutput("hit_ack",    64'(o_tcb.ack_num), 64'h2000);
    checkOutput("hit_win",    64'(o_tcb.window), 64'd512);
    checkOutput("hit_state",  64'(o_tcb.state), 64'(ESTABLISHED));
    checkOutput("hit_count",  64'(conn_count), 64'd1);
    finishDispatch(mkTcb(32'h0A00_0002, 16'd5000, 32'h1000, ESTABLISHED), 1'b1);
    checkOutput("pay_valid", {63'd0, tcp_payload_valid}, 64'd1);
    checkOutput("pay_addr",  64'(tcp_payload_addr), 64'h40);
    checkOutput("pay_conn",  64'(tcp_payload_conn), 64'd0);
    @(negedge clk);
    checkOutput("pay_pulse_end", {63'd0, tcp_payload_valid}, 64'd0);

    // Close slot 0
    applyStimulus(32'h0A00_0002, 16'd5000, 32'h1100, 32'h2100, 16'd512, 16'h50);
    @(negedge clk);
    checkOutput("close_idx", 64'(o_idx), 64'd0);
    finishDispatch(mkTcb(32'h0A00_0002, 16'd5000, 32'h1100, CLOSED), 1'b0);
    checkOutput("close_count", 64'(conn_count), 64'd0);

    // Fill the table with four new peers; slot 0 is reused first
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h0A00_0003 + 32'(k), 16'd6000 + 16'(k), 32'h0, 32'h0, 16'd64, 16'h0);
      @(negedge clk);
      checkOutput($sformatf("fill_idx%0d", k), 64'(o_idx), 64'(k));
      checkOutput($sformatf("fill_cnt%0d", k), 64'(conn_count), 64'(k + 1));
      finishDispatch(mkTcb(32'h0A00_0003 + 32'(k), 16'd6000 + 16'(k), 32'h0, ESTABLISHED), 1'b0);
    end

    // Fifth distinct peer with a full table
    applyStimulus(32'h0A00_0007, 16'd7000, 32'h0, 32'h0, 16'd64, 16'h0);
    checkOutput("full_lookup_drop", {63'd0, pkt_drop}, 64'd0);
    @(negedge clk);
`ifdef TCP_TCB_EVICT_EN
    checkOutput("evict_sm_valid", {63'd0, sm_valid}, 64'd1);
    checkOutput("evict_idx",      64'(o_idx), 64'd0);
    checkOutput("evict_port",     64'(o_tcb.peer_port), 64'd7000);
    checkOutput("evict_state",    64'(o_tcb.state), 64'(LISTEN));
    checkOutput("evict_drop",     {63'd0, pkt_drop}, 64'd0);
    checkOutput("evict_count",    64'(conn_count), 64'd4);
    finishDispatch(mkTcb(32'h0A00_0007, 16'd7000, 32'h0, ESTABLISHED), 1'b0);
`else
    checkOutput("drop_pulse",    {63'd0, pkt_drop}, 64'd1);
    checkOutput("drop_no_valid", {63'd0, sm_valid}, 64'd0);
    checkOutput("drop_ready",    {63'd0, ready}, 64'd1);
    @(negedge clk);
    checkOutput("drop_pulse_end", {63'd0, pkt_drop}, 64'd0);
    checkOutput("drop_no_valid2", {63'd0, sm_valid}, 64'd0);
    checkOutput("drop_count",     64'(conn_count), 64'd4);
`endif

    // Reset while dispatching peer 10.0.0.4:6001 (slot 1)
    applyStimulus(32'h0A00_0004, 16'd6001, 32'h77, 32'h0, 16'd64, 16'h0);
    @(negedge clk);
    checkOutput("pre_rst_valid", {63'd0, sm_valid}, 64'd1);
    checkOutput("pre_rst_idx",   64'(o_idx), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {63'd0, sm_valid}, 64'd0);
    checkOutput("mid_rst_count", 64'(conn_count), 64'd0);
    checkOutput("mid_rst_ready", {63'd0, ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rel_ready", {63'd0, ready}, 64'd1);
    applyStimulus(32'h0A00_0004, 16'd6001, 32'h88, 32'h0, 16'd64, 16'h0);
    @(negedge clk);
    checkOutput("realloc_idx",   64'(o_idx), 64'd0);
    checkOutput("realloc_state", 64'(o_tcb.state), 64'(LISTEN));
    checkOutput("realloc_count", 64'(conn_count), 64'd1);
    finishDispatch(mkTcb(32'h0A00_0004, 16'd6001, 32'h88, ESTABLISHED), 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
